// File: rtl/flash_arbiter.sv
// Arbitrates an instruction port and a data port onto one read-only flash
// controller, round-robin on ties, with an optional one-word read buffer.
module flash_arbiter #(
  parameter int BUFFER_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address_in,
  input  logic        i_sel_in,
  input  logic        i_read_in,
  output logic [31:0] i_read_value_out,
  output logic        i_ready_out,
  input  logic [31:0] d_address_in,
  input  logic        d_sel_in,
  input  logic        d_read_in,
  input  logic [3:0]  d_write_mask_in,
  output logic [31:0] d_read_value_out,
  output logic        d_ready_out,
  output logic [31:0] f_address_out,
  output logic        f_sel_out,
  output logic        f_read_out,
  input  logic [31:0] f_read_value_in,
  input  logic        f_ready_in
);
  // Handshake: a port requests by holding sel with read (data port: or a
  // non-zero write mask) until its one-cycle ready pulse; the flash side is
  // held with sel/read and a stable address until its one-cycle f_ready_in.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        port_q, port_d;
  logic [21:0] word_q, word_d;
  logic [31:0] result_q, result_d;
  logic        buf_valid_q, buf_valid_d;
  logic [21:0] buf_tag_q, buf_tag_d;
  logic [31:0] buf_data_q, buf_data_d;

  logic        i_req;
  logic        d_req;
  logic        d_write;
  logic        grant_port;
  logic [21:0] grant_word;
  logic        buf_hit;
  logic        unused_addr_bits;

  assign i_req      = i_sel_in & i_read_in;
  assign d_write    = |d_write_mask_in;
  assign d_req      = d_sel_in & (d_read_in | d_write);
  assign grant_port = (i_req & d_req) ? ~last_grant_q : d_req;
  assign grant_word = grant_port ? d_address_in[23:2] : i_address_in[23:2];
  assign buf_hit    = (BUFFER_EN != 0) && buf_valid_q && (buf_tag_q == grant_word);

  // Only a 16 MiB word-aligned window of flash is addressable.
  assign unused_addr_bits = ^{i_address_in[31:24], i_address_in[1:0],
                              d_address_in[31:24], d_address_in[1:0]};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    word_d       = word_q;
    result_d     = result_q;
    buf_valid_d  = buf_valid_q;
    buf_tag_d    = buf_tag_q;
    buf_data_d   = buf_data_q;
    case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          last_grant_d = grant_port;
          port_d       = grant_port;
          word_d       = grant_word;
          if ((grant_port == PORT_D) && d_write) begin
            result_d = 32'h0;
            state_d  = RESPOND;
          end else if (buf_hit) begin
            result_d = buf_data_q;
            state_d  = RESPOND;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (f_ready_in) begin
          result_d    = f_read_value_in;
          buf_data_d  = f_read_value_in;
          buf_tag_d   = word_q;
          buf_valid_d = 1'b1;
          state_d     = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_D;
      port_q       <= PORT_I;
      word_q       <= 22'h0;
      result_q     <= 32'h0;
      buf_valid_q  <= 1'b0;
      buf_tag_q    <= 22'h0;
      buf_data_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      word_q       <= word_d;
      result_q     <= result_d;
      buf_valid_q  <= buf_valid_d;
      buf_tag_q    <= buf_tag_d;
      buf_data_q   <= buf_data_d;
    end
  end

  // Flash side is quiet outside BUSY so the controller drops back to idle.
  assign f_sel_out        = (state_q == BUSY);
  assign f_read_out       = (state_q == BUSY);
  assign f_address_out    = (state_q == BUSY) ? {8'h00, word_q, 2'b00} : 32'h0;
  assign i_ready_out      = (state_q == RESPOND) && (port_q == PORT_I);
  assign d_ready_out      = (state_q == RESPOND) && (port_q == PORT_D);
  assign i_read_value_out = i_ready_out ? result_q : 32'h0;
  assign d_read_value_out = d_ready_out ? result_q : 32'h0;

endmodule
